rr_arb_mux_4_1: RTL and testbench
=================================

# rr_arb_mux_4_1

Round-robin arbitrated 4:1 channel selector. Sits directly upstream of `mux_4_1`: it arbitrates four valid/ready source channels and generates the 2-bit `sel` that steers the `mux_4_1` datapath. It also registers the selected word into a one-entry output stage with valid/ready, so four producers can share one consumer with fair, starvation-free access.

## Interface
- `WIDTH`, 4: data width of every channel; matches the `mux_4_1` `d0..d3`/`y` width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  4  per-channel valid; bit i belongs to `d{i}`.
- `d0`, `d1`, `d2`, `d3`  in  WIDTH each  channel data.
- `in_ready`  out  4  per-channel ready; at most one bit set (one-hot or zero).
- `sel`  out  2  index of the channel granted this cycle; feeds `mux_4_1`.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered selected word.
- `out_ready`  in  1  consumer accepts `out_data`.

## Operation
- State: `last` (2 bits, reset value 3), output register `out_data`/`out_valid` (reset 0/0). Output stage is a 2-state FSM: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_load` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- Priority order each cycle: `last+1`, `last+2`, `last+3`, `last` (mod 4). The grant goes to the first channel in that order with `in_valid`=1.
- `in_ready[g]`=1 only when `can_load`=1 and channel g is granted. All other bits are 0.
- Transfer on channel i occurs when `in_valid[i]` and `in_ready[i]` are both 1. On a transfer:
  - `out_data` ← `d{g}` via `mux_4_1` with `sel`=g.
  - `out_valid` ← 1.
  - `last` ← g.
- `sel`:
  - equals g whenever a grant exists;
  - otherwise holds `last`.
  - It is combinational from `in_valid`, `last` and the FSM state.
- No transfer and `out_ready`=1 while FULL → `out_valid` ← 0 (FULL→EMPTY). FULL with `out_ready`=0 → hold `out_data`/`out_valid` unchanged. No grant is issued in that case.
- Source rules:
  - Once a source asserts `in_valid`, it must hold `in_valid` and its data stable until accepted.
  - `in_valid` must not depend on `in_ready`.
  - `in_ready` may depend on `in_valid`. This combinational path is intended.
- Fairness: a continuously valid channel is granted within 4 grants.
- Reset mid-operation: the output word is discarded. Reset takes effect the same cycle `rst` is sampled high, and `in_ready`=0 while `rst`=1.

## Timing
- Latency: a word accepted in cycle N appears on `out_data` with `out_valid`=1 in cycle N+1.
- Throughput: 1 word/cycle when `out_ready` is held at 1.
- Stall: with `out_ready`=0 and FULL, `in_ready`=0 until the cycle `out_ready` rises. The refill happens in that same cycle, so no bubble is inserted.
- The pointer advances only on a transfer. Idle cycles do not rotate priority.
- Simultaneous drain and load: the new word replaces the old at the edge, and `out_valid` stays 1.
- After reset release, the first grant favours channel 0 (`last`=3).

## Structure
- Shared package `mux_pkg`:
  - `localparam N_CH = 4`
  - `localparam SEL_W = 2`
  - `typedef logic [SEL_W-1:0] sel_t`
  - `localparam sel_t LAST_RST = 2'd3`
- Sub-module: instantiate the existing `mux_4_1` for the data path, driven by `sel`. The grant/priority logic stays inline; no further sub-modules.

## Test plan
- Reset, all `in_valid`=0 → `out_valid`=0, `out_data`=0, `in_ready`=0000, `sel`=3.
- `in_valid`=1111, `d0..d3`=A,B,C,D held, `out_ready`=1 → grants in order 0,1,2,3,0; `out_data` sequence A,B,C,D,A starting the cycle after the first grant.
- Only channel 2 valid (`d2`=5), `out_ready`=1 → `in_ready`=0100, `sel`=2; next cycle `out_data`=5, `out_valid`=1; then `out_valid` drops if there is no new request.
- Output FULL with `out_ready`=0 for 3 cycles, `in_valid`=0011 → `in_ready`=0000 and `out_data` stable; when `out_ready`=1, the next grant is issued in that same cycle.
- `last`=1 with `in_valid`=1001 → channel 3 granted before channel 0; the following grant goes to 0.
- `rst` pulsed while FULL with pending requests → next cycle `out_valid`=0, and the first post-reset grant goes to channel 0 if `in_valid[0]`=1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 channel selector and its round-robin arbiter.
//   N_CH     : number of source channels
//   SEL_W    : width of the channel select index
//   sel_t    : channel select index type
//   LAST_RST : pointer value after reset, so channel 0 is favoured first
//   out_state_e : occupancy of the one-entry output register
package mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t LAST_RST = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arb_mux_4_1_if.sv
// Handshake bundle between four producers, the arbiter and one consumer.
//   in_valid / d0..d3 : per-channel request and data (producer side)
//   in_ready          : per-channel accept, at most one bit set
//   sel               : granted channel index, steers the datapath mux
//   out_valid / out_data / out_ready : registered output handshake
// Modports: slave = the arbiter, master = the environment driving it.
interface rr_arb_mux_4_1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [N_CH-1:0]  in_valid;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [N_CH-1:0]  in_ready;
  sel_t             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, sel, out_valid, out_data
  );

  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 multiplexer.
//   d0..d3 : data inputs
//   sel    : selects which input drives y
//   y      : selected data
module mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbitrated 4:1 channel selector with a one-entry registered
// output stage. Four valid/ready producers share one consumer; the channel
// after the most recently served one gets first priority.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : handshake bundle (slave side), see rr_arb_mux_4_1_if
module rr_arb_mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  rr_arb_mux_4_1_if.slave         bus
);

  out_state_e       state;
  sel_t             last;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  logic             can_load;
  logic             found;
  logic             has_grant;
  sel_t             gnt;
  sel_t             idx;
  sel_t             sel;
  logic [WIDTH-1:0] mux_y;

  // Scan last+1, last+2, last+3, last (mod 4) and take the first valid
  // channel. A grant only exists when the output register can accept a
  // word this cycle; reset suppresses it so in_ready stays low.
  always_comb begin
    can_load = (state == EMPTY) || bus.out_ready;
    found    = 1'b0;
    gnt      = last;
    idx      = last;
    for (int k = 1; k <= N_CH; k++) begin
      idx = last + sel_t'(k);
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    has_grant = can_load && found && !rst;
    sel       = has_grant ? gnt : last;
  end

  mux_4_1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .sel(sel),
    .y  (mux_y)
  );

  // Output stage. A grant always implies a transfer because the granted
  // channel is valid by construction, so loading keys off has_grant alone.
  // Draining and refilling in the same cycle keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      last      <= LAST_RST;
    end else begin
      case (state)
        EMPTY: begin
          if (has_grant) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= mux_y;
            last      <= gnt;
          end
        end
        FULL: begin
          if (has_grant) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            last      <= gnt;
          end else if (bus.out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = has_grant ? (N_CH'(1) << gnt) : '0;
  assign bus.sel       = sel;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Testbench for rr_arb_mux_4_1: directed per-cycle vectors with expected
// in_ready/sel, plus a scoreboard of expected output words that a separate
// monitor pops whenever the consumer takes a word.
module tb_rr_arb_mux_4_1;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_arb_mux_4_1_if #(.WIDTH(4)) bus ();

  rr_arb_mux_4_1 #(
    .WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, then check the
  // combinational grant outputs and queue the word expected to be loaded.
  task automatic apply_stimulus(input logic r, input logic [3:0] iv,
                                input logic [15:0] data, input logic ordy,
                                input logic [3:0] exp_rdy, input logic chk_sel,
                                input logic [1:0] exp_sel, input logic [3:0] exp_word);
    @(posedge clk);
    #1;
    if (r) exp_q.delete();
    rst           = r;
    bus.in_valid  = iv;
    bus.d0        = data[3:0];
    bus.d1        = data[7:4];
    bus.d2        = data[11:8];
    bus.d3        = data[15:12];
    bus.out_ready = ordy;
    #1;
    check_output("in_ready", {4'b0, bus.in_ready}, {4'b0, exp_rdy});
    if (chk_sel) check_output("sel", {6'b0, bus.sel}, {6'b0, exp_sel});
    if (exp_rdy != 4'b0000 && !r) exp_q.push_back(exp_word);
  endtask

  // Monitor: every word the consumer accepts must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL out_word: got %0h, expected no word at %0t", bus.out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("out_data", {4'b0, bus.out_data}, {4'b0, mon_exp});
      end
    end
  end

  initial begin
    bus.in_valid  = 4'b0000;
    bus.d0        = 4'h0;
    bus.d1        = 4'h0;
    bus.d2        = 4'h0;
    bus.d3        = 4'h0;
    bus.out_ready = 1'b0;

    // Reset with requests present: nothing may be granted.
    apply_stimulus(1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
    apply_stimulus(1'b0, 4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b1, 2'd3, 4'h0);
    check_output("rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
    check_output("rst_out_data", {4'b0, bus.out_data}, 8'h00);

    // All four valid: rotation 0,1,2,3,0 at full throughput.
    apply_stimulus(1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    apply_stimulus(1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    apply_stimulus(1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC);
    apply_stimulus(1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    apply_stimulus(1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);

    // Only channel 2 valid, then idle: word appears once and output drains.
    apply_stimulus(1'b0, 4'b0100, 16'h0500, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h5);
    apply_stimulus(1'b0, 4'b0000, 16'h0500, 1'b1, 4'b0000, 1'b1, 2'd2, 4'h0);
    check_output("ch2_out_valid", {7'b0, bus.out_valid}, 8'h01);
    check_output("ch2_out_data", {4'b0, bus.out_data}, 8'h05);
    apply_stimulus(1'b0, 4'b0000, 16'h0500, 1'b1, 4'b0000, 1'b1, 2'd2, 4'h0);
    check_output("drain_out_valid", {7'b0, bus.out_valid}, 8'h00);

    // Stall: fill from empty, hold out_ready low, then refill on release.
    apply_stimulus(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0001, 1'b1, 2'd0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h0);
      check_output("stall_out_valid", {7'b0, bus.out_valid}, 8'h01);
      check_output("stall_out_data", {4'b0, bus.out_data}, 8'h01);
    end
    apply_stimulus(1'b0, 4'b0011, 16'h0021, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h2);

    // last=1 with channels 3 and 0 valid: 3 wins, then 0.
    apply_stimulus(1'b0, 4'b1001, 16'h9007, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h9);
    apply_stimulus(1'b0, 4'b1001, 16'h9007, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h7);

    // Reset while full with pending requests: word dropped, channel 0 first.
    apply_stimulus(1'b1, 4'b1111, 16'h6543, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
    apply_stimulus(1'b0, 4'b1111, 16'h6543, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h3);
    check_output("post_rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
    apply_stimulus(1'b0, 4'b0000, 16'h6543, 1'b1, 4'b0000, 1'b1, 2'd0, 4'h0);
    apply_stimulus(1'b0, 4'b0000, 16'h6543, 1'b1, 4'b0000, 1'b1, 2'd0, 4'h0);
    check_output("final_out_valid", {7'b0, bus.out_valid}, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
